branch_redirect_ctrl: RTL and testbench



---
 rtl/branch_redirect_ctrl_pkg.sv | 34 +++
 rtl/branch_redirect_ctrl_if.sv | 25 ++
 rtl/branch_redirect_ctrl_bpu_upd_fifo.sv | 52 +++++
 rtl/branch_redirect_ctrl.sv | 97 +++++++++
 tb/tb_branch_redirect_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared execute-stage definitions: ALU opcodes, redirect FSM encodings and
// the predictor-update entry layout used by the redirect controller.
package branch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    localparam int DEF_FIFO_DEPTH = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REDIR  = 2'd1;
    localparam logic [1:0] ST_SQUASH = 2'd2;

    // 65-bit queue entry, packed as {taken, pc, target}
    typedef struct packed {
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
    } bpu_upd_t;

    function automatic bpu_upd_t make_upd(input logic taken, input logic [31:0] pc,
                                          input logic [31:0] target);
        bpu_upd_t e;
        e.taken  = taken;
        e.pc     = pc;
        e.target = target;
        return e;
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Frontend redirect handshake and branch-predictor update handshake.
interface branch_redirect_ctrl_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        bpu_upd_valid;
    logic [31:0] bpu_upd_pc;
    logic        bpu_upd_taken;
    logic [31:0] bpu_upd_target;
    logic        bpu_upd_ready;

    modport master (
        output redirect_valid, redirect_pc,
        input  redirect_ready,
        output bpu_upd_valid, bpu_upd_pc, bpu_upd_taken, bpu_upd_target,
        input  bpu_upd_ready
    );

    modport slave (
        input  redirect_valid, redirect_pc,
        output redirect_ready,
        input  bpu_upd_valid, bpu_upd_pc, bpu_upd_taken, bpu_upd_target,
        output bpu_upd_ready
    );
endinterface

// File: rtl/branch_redirect_ctrl_bpu_upd_fifo.sv
// Predictor-update queue: two write ports (port 0 lands first), one read port
// with the head entry visible combinationally while occupancy is non-zero.
module bpu_upd_fifo
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we0,
    input  bpu_upd_t                 wd0,
    input  logic                     we1,
    input  bpu_upd_t                 wd1,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output bpu_upd_t                 rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    bpu_upd_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic [AW-1:0]   wr1_addr;
    logic [1:0]      n_push;
    logic            pop;

    assign n_push   = {1'b0, we0} + {1'b0, we1};
    assign wr1_addr = we0 ? wr_ptr_q + AW'(1) : wr_ptr_q;
    assign rd_valid = (count_q != '0);
    assign pop      = rd_en & rd_valid;
    // Zero the data lanes when empty so idle/reset outputs are clean
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (we0) mem_q[wr_ptr_q] <= wd0;
        if (we1) mem_q[wr1_addr] <= wd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(n_push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_q + (AW+1)'(n_push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/branch_redirect_ctrl.sv
// Two-lane branch resolution: picks the oldest flushing lane, drives the
// frontend redirect FSM, counts mispredicts and queues predictor updates.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           ex_valid_i,
    input  logic [1:0]           ex_flush_i,
    input  logic [1:0]           ex_update_en_i,
    input  logic [1:0]           ex_taken_i,
    input  logic [1:0][31:0]     ex_pc_i,
    input  logic [1:0][31:0]     ex_target_i,
    output logic                 flush_o,
    output logic                 stall_o,
    output logic [CNT_W-1:0]     mispredict_cnt,
    branch_redirect_ctrl_if.master brc_if
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       state_q, state_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]    occ;
    logic [1:0]       lane_flush;
    logic [1:0]       push;
    bpu_upd_t         upd_entry [2];
    bpu_upd_t         head;
    logic             sample, win0, win1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign lane_flush[gi] = ex_valid_i[gi] & ex_flush_i[gi];
        assign upd_entry[gi]  = make_upd(ex_taken_i[gi], ex_pc_i[gi], ex_target_i[gi]);
    end

    // Stall keeps two free slots so a dual push can never overflow
    assign stall_o = (occ > CW'(FIFO_DEPTH - 2));
    assign sample  = (state_q == ST_IDLE) & ~stall_o;
    assign win0    = sample & lane_flush[0];
    assign win1    = sample & ~lane_flush[0] & lane_flush[1];
    assign push[0] = sample & ex_valid_i[0] & ex_update_en_i[0];
    assign push[1] = sample & ex_valid_i[1] & ex_update_en_i[1] & ~lane_flush[0];

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        cnt_d         = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win0 | win1) begin
                    state_d       = ST_REDIR;
                    redirect_pc_d = win0 ? ex_target_i[0] : ex_target_i[1];
                    cnt_d         = cnt_q + CNT_W'(1);
                end
            end
            ST_REDIR:  if (brc_if.redirect_ready) state_d = ST_SQUASH;
            ST_SQUASH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            redirect_pc_q <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            cnt_q         <= cnt_d;
        end
    end

    bpu_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_upd_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .we0      (push[0]),
        .wd0      (upd_entry[0]),
        .we1      (push[1]),
        .wd1      (upd_entry[1]),
        .rd_en    (brc_if.bpu_upd_ready),
        .rd_valid (brc_if.bpu_upd_valid),
        .rd_data  (head),
        .count    (occ)
    );

    assign brc_if.redirect_valid = (state_q == ST_REDIR);
    assign brc_if.redirect_pc    = redirect_pc_q;
    assign brc_if.bpu_upd_taken  = head.taken;
    assign brc_if.bpu_upd_pc     = head.pc;
    assign brc_if.bpu_upd_target = head.target;
    assign flush_o               = (state_q != ST_IDLE);
    assign mispredict_cnt        = cnt_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: stimulus queues expected redirects
// and predictor updates; a negedge monitor pops and compares on each handshake.
module tb_branch_redirect_ctrl;
    import branch_redirect_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        v, fl, ue, tk;
    logic [1:0][31:0]  pc, tg;
    logic              flush_o, stall_o;
    logic [CW-1:0]     cnt;

    int                checks = 0;
    int                errors = 0;
    logic [31:0]       exp_redir [$];
    bpu_upd_t          exp_bpu [$];
    logic [CW-1:0]     exp_cnt;

    branch_redirect_ctrl_if brc_if ();

    branch_redirect_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid_i     (v),
        .ex_flush_i     (fl),
        .ex_update_en_i (ue),
        .ex_taken_i     (tk),
        .ex_pc_i        (pc),
        .ex_target_i    (tg),
        .flush_o        (flush_o),
        .stall_o        (stall_o),
        .mispredict_cnt (cnt),
        .brc_if         (brc_if)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [64:0] act, input logic [64:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic vv, input logic ff, input logic uu,
                            input logic tt, input logic [31:0] p, input logic [31:0] t);
        v[i] = vv; fl[i] = ff; ue[i] = uu; tk[i] = tt; pc[i] = p; tg[i] = t;
    endtask

    task automatic clear_lanes();
        v = '0; fl = '0; ue = '0; tk = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (flush_o && n < 20) begin
            cyc();
            n++;
        end
        check("wait_idle", flush_o, 0);
    endtask

    // Monitor: one line per observed transaction
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && brc_if.redirect_valid && brc_if.redirect_ready) begin
                if (exp_redir.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL redir_unexpected actual_pc=%h required=none", brc_if.redirect_pc);
                end else begin
                    $display("redirect pc=%h", brc_if.redirect_pc);
                    check("redir_pc", brc_if.redirect_pc, exp_redir.pop_front());
                end
            end
            if (rst_n && brc_if.bpu_upd_valid && brc_if.bpu_upd_ready) begin
                if (exp_bpu.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bpu_unexpected actual_pc=%h required=none", brc_if.bpu_upd_pc);
                end else begin
                    $display("bpu pop taken=%0d pc=%h target=%h", brc_if.bpu_upd_taken,
                             brc_if.bpu_upd_pc, brc_if.bpu_upd_target);
                    check("bpu_pop", {brc_if.bpu_upd_taken, brc_if.bpu_upd_pc, brc_if.bpu_upd_target},
                          exp_bpu.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_lanes(); pc = '0; tg = '0;
        brc_if.redirect_ready = 1'b0;
        brc_if.bpu_upd_ready  = 1'b0;
        exp_cnt = '0;

        // Reset state
        #2;
        check("rst_valid", brc_if.redirect_valid, 0);
        check("rst_pc", brc_if.redirect_pc, 0);
        check("rst_flush", flush_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_bpu_valid", brc_if.bpu_upd_valid, 0);
        check("rst_bpu_data", {brc_if.bpu_upd_taken, brc_if.bpu_upd_pc, brc_if.bpu_upd_target}, 0);
        check("rst_cnt", cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("idle_flush", flush_o, 0);

        // Lane 0 flush, frontend stalls redirect for 3 cycles
        set_lane(0, 1, 1, 0, 1, 32'h1C0000F0, 32'h1C000100);
        exp_redir.push_back(32'h1C000100); exp_cnt++;
        cyc(); clear_lanes();
        check("t1_valid", brc_if.redirect_valid, 1);
        check("t1_pc", brc_if.redirect_pc, 32'h1C000100);
        check("t1_flush", flush_o, 1);
        check("t1_cnt", cnt, 1);
        repeat (3) begin
            cyc();
            check("t1_hold_valid", brc_if.redirect_valid, 1);
            check("t1_hold_pc", brc_if.redirect_pc, 32'h1C000100);
            check("t1_hold_flush", flush_o, 1);
        end
        brc_if.redirect_ready = 1'b1;
        cyc();
        check("t1_squash_valid", brc_if.redirect_valid, 0);
        check("t1_squash_flush", flush_o, 1);
        cyc();
        check("t1_idle_flush", flush_o, 0);

        // Both lanes flush: lane 0 wins, lane 1 update discarded
        brc_if.bpu_upd_ready = 1'b1;
        set_lane(0, 1, 1, 1, 1, 32'h40, 32'h100);
        set_lane(1, 1, 1, 1, 0, 32'h44, 32'h200);
        exp_redir.push_back(32'h100); exp_bpu.push_back(make_upd(1'b1, 32'h40, 32'h100)); exp_cnt++;
        cyc(); clear_lanes();
        check("t2_pc", brc_if.redirect_pc, 32'h100);
        check("t2_cnt", cnt, 2);
        check("t2_bpu_head", brc_if.bpu_upd_pc, 32'h40);
        wait_idle();
        check("t2_bpu_empty", brc_if.bpu_upd_valid, 0);

        // Lane 1 alone flushes; both lanes push updates
        set_lane(0, 1, 0, 1, 0, 32'h50, 32'h54);
        set_lane(1, 1, 1, 1, 1, 32'h58, 32'h500);
        exp_bpu.push_back(make_upd(1'b0, 32'h50, 32'h54));
        exp_bpu.push_back(make_upd(1'b1, 32'h58, 32'h500));
        exp_redir.push_back(32'h500); exp_cnt++;
        cyc(); clear_lanes();
        check("t3_pc", brc_if.redirect_pc, 32'h500);
        check("t3_cnt", cnt, 3);
        wait_idle();
        check("t3_bpu_empty", brc_if.bpu_upd_valid, 0);

        // Fill queue with dual pushes while predictor is not ready
        brc_if.bpu_upd_ready = 1'b0;
        set_lane(0, 1, 0, 1, 1, 32'h1000, 32'h2000);
        set_lane(1, 1, 0, 1, 0, 32'h1004, 32'h2004);
        exp_bpu.push_back(make_upd(1'b1, 32'h1000, 32'h2000));
        exp_bpu.push_back(make_upd(1'b0, 32'h1004, 32'h2004));
        cyc();
        check("t4_stall_half", stall_o, 0);
        check("t4_valid_half", brc_if.bpu_upd_valid, 1);
        set_lane(0, 1, 0, 1, 0, 32'h1008, 32'h3000);
        set_lane(1, 1, 0, 1, 1, 32'h100C, 32'h3004);
        exp_bpu.push_back(make_upd(1'b0, 32'h1008, 32'h3000));
        exp_bpu.push_back(make_upd(1'b1, 32'h100C, 32'h3004));
        cyc();
        check("t4_stall_full", stall_o, 1);
        check("t4_head", {brc_if.bpu_upd_taken, brc_if.bpu_upd_pc, brc_if.bpu_upd_target},
              {1'b1, 32'h1000, 32'h2000});
        set_lane(0, 1, 0, 1, 1, 32'h9990, 32'h9994);
        set_lane(1, 1, 0, 1, 1, 32'h9998, 32'h999C);
        cyc();
        check("t4_stall_hold", stall_o, 1);
        check("t4_head_hold", brc_if.bpu_upd_pc, 32'h1000);
        check("t4_flush", flush_o, 0);
        clear_lanes();
        brc_if.bpu_upd_ready = 1'b1;
        #1;
        check("t4_stall_pop", stall_o, 1);
        repeat (4) cyc();
        check("t4_drained", brc_if.bpu_upd_valid, 0);
        check("t4_unstall", stall_o, 0);

        // Lane 1 flush while in REDIR / SQUASH is ignored
        brc_if.redirect_ready = 1'b0;
        set_lane(0, 1, 1, 0, 0, 32'h60, 32'h300);
        exp_redir.push_back(32'h300); exp_cnt++;
        cyc(); clear_lanes();
        set_lane(1, 1, 1, 0, 0, 32'h64, 32'h400);
        cyc();
        check("t5_valid", brc_if.redirect_valid, 1);
        check("t5_pc", brc_if.redirect_pc, 32'h300);
        brc_if.redirect_ready = 1'b1;
        cyc();
        check("t5_squash_valid", brc_if.redirect_valid, 0);
        cyc(); clear_lanes();
        check("t5_idle_flush", flush_o, 0);
        repeat (2) cyc();
        check("t5_cnt", cnt, 4);
        check("t5_no_redir", brc_if.redirect_valid, 0);

        // Asynchronous reset mid-redirect with 3 queued entries
        brc_if.redirect_ready = 1'b0;
        brc_if.bpu_upd_ready  = 1'b0;
        set_lane(0, 1, 0, 1, 0, 32'h80, 32'h84);
        set_lane(1, 1, 0, 1, 1, 32'h88, 32'h8C);
        cyc(); clear_lanes();
        set_lane(0, 1, 1, 1, 0, 32'h70, 32'h700);
        exp_cnt++;
        cyc(); clear_lanes();
        check("t6_valid", brc_if.redirect_valid, 1);
        check("t6_stall", stall_o, 1);
        check("t6_cnt", cnt, exp_cnt);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", brc_if.redirect_valid, 0);
        check("t6_rst_pc", brc_if.redirect_pc, 0);
        check("t6_rst_flush", flush_o, 0);
        check("t6_rst_bpu_valid", brc_if.bpu_upd_valid, 0);
        check("t6_rst_bpu_data", {brc_if.bpu_upd_taken, brc_if.bpu_upd_pc, brc_if.bpu_upd_target}, 0);
        check("t6_rst_stall", stall_o, 0);
        check("t6_rst_cnt", cnt, 0);
        exp_redir.delete(); exp_bpu.delete(); exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("t6_post_bpu_valid", brc_if.bpu_upd_valid, 0);
        check("t6_post_flush", flush_o, 0);

        // 17 mispredicts wrap a 4-bit counter to 1
        brc_if.redirect_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            set_lane(k % 2, 1, 1, 0, 0, 32'h10 + 32'(k), 32'h8000 + 32'(k * 4));
            exp_redir.push_back(32'h8000 + 32'(k * 4)); exp_cnt++;
            cyc(); clear_lanes();
            cyc();
            cyc();
        end
        check("t7_cnt_wrap", cnt, 4'd1);

        repeat (3) cyc();
        check("redir_q_empty", exp_redir.size(), 0);
        check("bpu_q_empty", exp_bpu.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
